// File: rtl/multiplexador_rr_parametrizado.sv
// multiplexador_rr_parametrizado: CHANNELS x WIDTH valid/ready merger with manual or round-robin
// grant into one registered output stage. Define MUX_TRANSFER_COUNT_EN to add the out_count port.
module multiplexador_rr_parametrizado #(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      modo,
   input  logic [SEL_W-1:0]          seletor,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_sel
`ifdef MUX_TRANSFER_COUNT_EN
   ,
   output logic [15:0]               out_count
`endif
);

   logic             load_s;
   logic             rr_found_s;
   logic             rr_hit_s;
   logic             man_found_s;
   logic             grant_s;
   logic [SEL_W-1:0] rr_idx_s;
   logic [SEL_W-1:0] scan_idx_s;
   logic [SEL_W-1:0] grant_idx_s;
   logic [SEL_W-1:0] ptr_r;

   assign load_s = !out_valid || out_ready;

   // Round-robin scan: ptr+1 first, wrapping, ptr itself last
   always_comb begin
      rr_found_s = 1'b0;
      rr_hit_s   = 1'b0;
      rr_idx_s   = '0;
      scan_idx_s = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         scan_idx_s = SEL_W'((int'(ptr_r) + i) % CHANNELS);
         rr_hit_s   = in_valid[scan_idx_s] && !rr_found_s;
         rr_idx_s   = rr_hit_s ? scan_idx_s : rr_idx_s;
         rr_found_s = rr_found_s | rr_hit_s;
      end
   end

   // Manual grant; an index beyond the channel count never grants
   always_comb begin
      if (int'(seletor) < CHANNELS) begin
         man_found_s = in_valid[seletor];
      end else begin
         man_found_s = 1'b0;
      end
   end

   // Mode select for the grant candidate
   always_comb begin
      grant_s     = 1'b0;
      grant_idx_s = '0;
      case (modo)
         1'b1: begin
            grant_s     = man_found_s;
            grant_idx_s = seletor;
         end
         default: begin
            grant_s     = rr_found_s;
            grant_idx_s = rr_idx_s;
         end
      endcase
   end

   // Ready goes only to the granted channel, and only when the output stage can load
   always_comb begin
      in_ready = '0;
      if (rst_n && load_s && grant_s) begin
         in_ready[grant_idx_s] = 1'b1;
      end else begin
         in_ready = '0;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr_r     <= SEL_W'(CHANNELS - 1);
      end else if (load_s) begin
         if (grant_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
            out_sel   <= grant_idx_s;
            if (modo == 1'b0) begin
               ptr_r <= grant_idx_s;
            end else begin
               ptr_r <= ptr_r;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX_TRANSFER_COUNT_EN
   logic [15:0] count_r;

   // Count accepted output words, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= 16'd0;
      end else if (out_valid && out_ready) begin
         count_r <= count_r + 16'd1;
      end
   end

   assign out_count = count_r;
`endif

endmodule

// File: tb/tb_multiplexador_rr_parametrizado.sv
// Directed self-checking bench for multiplexador_rr_parametrizado (WIDTH=4, CHANNELS=8).
// Channel k carries data k+8 so out_data identifies the source channel.
module tb_multiplexador_rr_parametrizado;
   localparam int WIDTH    = 4;
   localparam int CHANNELS = 8;
   localparam int SEL_W    = 3;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      modo;
   logic [SEL_W-1:0]          seletor;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SEL_W-1:0]          out_sel;
`ifdef MUX_TRANSFER_COUNT_EN
   logic [15:0]               out_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   multiplexador_rr_parametrizado #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .modo      (modo),
      .seletor   (seletor),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
`ifdef MUX_TRANSFER_COUNT_EN
      ,
      .out_count (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input int s, input int d);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".sel"},   32'(out_sel),   32'(s));
      chk({tag, ".data"},  32'(out_data),  32'(d));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int rel_sel [3] = '{7, 0, 1};

   initial begin
      rst_n     = 1'b0;
      modo      = 1'b0;
      seletor   = 3'd0;
      in_data   = 32'hFEDC_BA98;
      in_valid  = 8'hFF;
      out_ready = 1'b1;

      // reset with every channel valid
      tick();
      tick();
      chk_out("reset", 1'b0, 0, 0);
      chk("reset.in_ready", 32'(in_ready), 32'h00);
      rst_n = 1'b1;
      #1;
      chk("rr_first.in_ready", 32'(in_ready), 32'h01);

      // fairness: 0..7 then 0
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_out("rr_fair", 1'b1, i % 8, 8 + (i % 8));
         chk("rr_fair.in_ready", 32'(in_ready), 32'(8'h01 << ((i + 1) % 8)));
      end

      // sparse: channels 2 and 5
      in_valid = 8'h24;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out("rr_sparse", 1'b1, (i % 2 == 0) ? 2 : 5, (i % 2 == 0) ? 10 : 13);
      end
      in_valid = 8'h20;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rr_only5", 1'b1, 5, 13);
      end

      // manual channel 3
      modo     = 1'b1;
      seletor  = 3'd3;
      in_valid = 8'hFF;
      #1;
      chk("manual.in_ready", 32'(in_ready), 32'h08);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("manual", 1'b1, 3, 11);
         chk("manual.in_ready_hold", 32'(in_ready), 32'h08);
      end
      in_valid = 8'hF7;
      #1;
      chk("manual_drop.in_ready", 32'(in_ready), 32'h00);
      tick();
      chk_out("manual_drop", 1'b0, 3, 11);
      chk("manual_drop.in_ready2", 32'(in_ready), 32'h00);

      // backpressure: ptr still 5 from round-robin, so channel 6 next
      modo     = 1'b0;
      in_valid = 8'hFF;
      #1;
      chk("bp_pre.in_ready", 32'(in_ready), 32'h40);
      tick();
      chk_out("bp_load", 1'b1, 6, 14);
      out_ready = 1'b0;
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out("bp_hold", 1'b1, 6, 14);
         chk("bp_hold.in_ready", 32'(in_ready), 32'h00);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release.in_ready", 32'(in_ready), 32'h80);
      chk("bp_consumed", 32'(out_sel), 32'd6);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("bp_stream", 1'b1, rel_sel[i], 8 + rel_sel[i]);
      end

      // mode change while the word is held
      out_ready = 1'b0;
      modo      = 1'b1;
      seletor   = 3'd4;
      #1;
      chk("modechg.in_ready", 32'(in_ready), 32'h00);
      tick();
      chk_out("modechg_hold", 1'b1, 1, 9);
      out_ready = 1'b1;
      #1;
      chk("modechg.in_ready2", 32'(in_ready), 32'h10);
      tick();
      chk_out("modechg_next", 1'b1, 4, 12);

      // reset mid-transfer, ptr must return to CHANNELS-1
      rst_n = 1'b0;
      #1;
      chk("midreset.in_ready", 32'(in_ready), 32'h00);
      tick();
      chk_out("midreset", 1'b0, 0, 0);
      rst_n = 1'b1;
      modo  = 1'b0;
      #1;
      chk("after_reset.in_ready", 32'(in_ready), 32'h01);
      tick();
      chk_out("after_reset", 1'b1, 0, 8);

`ifdef MUX_TRANSFER_COUNT_EN
      rst_n = 1'b0;
      tick();
      chk("count_reset", 32'(out_count), 32'd0);
      rst_n = 1'b1;
      repeat (70001) tick();
      chk("count_wrap", 32'(out_count), 32'd4464);
      rst_n = 1'b0;
      tick();
      chk("count_midreset", 32'(out_count), 32'd0);
      rst_n = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/multiplexador_rr_parametrizado.md
Name: multiplexador_rr_parametrizado

Overview:
- Parametrised successor to the 8:1 4-bit behavioural mux: CHANNELS inputs of WIDTH bits each, merged onto one registered output stream.
- Each input and the output use a valid/ready handshake.
- Two modes, set by `modo`: manual selection (index on `seletor`) or round-robin arbitration across all valid channels.
- Used wherever several producers share one consumer, for example display or ALU operand sources.

Parameters:
- WIDTH, 4, data width per channel.
- CHANNELS, 8, number of input channels (legal range 2..64).
- SEL_W, $clog2(CHANNELS), width of the channel index. Localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- modo  in  1  0 = round-robin, 1 = manual via `seletor`.
- seletor  in  SEL_W  channel index used in manual mode.
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel k occupies [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; one-hot or zero.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority.
  - in_ready is 0 while rst_n=0.
- Load condition: load = !out_valid || out_ready. Single output register, one transfer per cycle sustained, latency 1 cycle from input handshake to out_valid.
- Grant selection (combinational, only when load=1):
  - Manual (modo=1): grant g=seletor if seletor<CHANNELS and in_valid[seletor]=1; otherwise no grant. Other valid channels wait.
  - Round-robin (modo=0): g is the first k with in_valid[k]=1, scanning ptr+1, ptr+2, … and wrapping modulo CHANNELS. ptr itself is checked last. No valid channel means no grant.
- in_ready[g]=1 only when load=1 and a grant exists; all other bits are 0. in_ready may depend combinationally on in_valid, modo, seletor and out_ready.
- At posedge with load=1:
  - Grant: out_data<=channel g data, out_sel<=g, out_valid<=1. In round-robin mode ptr<=g; in manual mode ptr is unchanged.
  - No grant: out_valid<=0; out_data and out_sel hold.
- At posedge with load=0 (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold and stay stable; all in_ready=0.
- Simultaneous consume and refill (out_valid=1, out_ready=1, a valid input) gives back-to-back words with no bubble.
- Changing modo or seletor mid-stream affects only the next grant; the word already in the output register is not altered.
- Reset asserted mid-transfer discards the output word (out_valid=0 next cycle) and resets ptr. No partial state survives.
- Fairness: with all channels continuously valid and out_ready=1, round-robin grants 0,1,…,CHANNELS-1,0,…

Optional Feature:
- Macro MUX_TRANSFER_COUNT_EN.
- When defined:
  - Extra output port `out_count`, out, 16 bits.
  - Increments by 1 on each cycle with out_valid && out_ready, wrapping 0xFFFF→0x0000.
  - Reset value 0. Synchronous clear on rst_n=0 only.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. First grant after release is channel 0 (modo=0).
- Round-robin fairness (WIDTH=4, CHANNELS=8, in_data channel k = k+8, all valid, out_ready=1) -> out_sel sequence 0..7,0 and out_data 8..15,8, one word per cycle.
- Sparse round-robin: only channels 2 and 5 valid -> out_sel alternates 2,5,2,5. Then channel 2 drops -> out_sel stays 5 every cycle.
- Manual mode: modo=1, seletor=3, in_valid=0xFF -> only in_ready[3]=1 and out_sel=3 every cycle. Set in_valid[3]=0 -> out_valid falls to 0 one cycle later, in_ready=0.
- Backpressure: out_ready=0 for 4 cycles with a word loaded -> out_data and out_sel stable, in_ready=0. Release -> next word the following cycle with no bubble and no lost or duplicated word (scoreboard).
- With MUX_TRANSFER_COUNT_EN: 70000 transfers -> out_count = 70000 mod 65536 = 4464. Reset mid-run -> 0.
